// File: rtl/cv32e40p_apu_resp_buffer.sv
// APU response buffer: captures every non-back-pressurable FPU result into a FIFO,
// meters upstream issue with credits, and accumulates sticky fflags.
module cv32e40p_apu_resp_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLAG_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_i,
  output logic                       issue_allow_o,
  input  logic                       apu_rvalid_i,
  input  logic [31:0]                apu_rdata_i,
  input  logic [FLAG_W-1:0]          apu_rflags_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [31:0]                wb_rdata_o,
  output logic [FLAG_W-1:0]          wb_rflags_o,
  output logic [FLAG_W-1:0]          fflags_acc_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       proto_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 32 + FLAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  occupancy_q, occupancy_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FLAG_W-1:0] fflags_acc_q, fflags_acc_d;
  logic              proto_err_q, proto_err_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic [CNT_W-1:0]  in_flight;
  logic [ENT_W-1:0]  head;
  logic              issue_ok, issue_bad, push, spurious, pop;

  assign head          = mem_q[rd_ptr_q];
  assign issue_allow_o = (outstanding_q < DEPTH_C);
  assign wb_valid_o    = (occupancy_q != '0);
  assign wb_rdata_o    = head[ENT_W-1:FLAG_W];
  assign wb_rflags_o   = head[FLAG_W-1:0];
  assign fflags_acc_o  = fflags_acc_q;
  assign outstanding_o = outstanding_q;
  assign proto_err_o   = proto_err_q;

  // All legality decisions use pre-edge register values only.
  assign in_flight = outstanding_q - occupancy_q;
  assign issue_ok  = issue_i && issue_allow_o;
  assign issue_bad = issue_i && !issue_allow_o;
  assign push      = apu_rvalid_i && (in_flight != '0);
  assign spurious  = apu_rvalid_i && (in_flight == '0);
  assign pop       = wb_valid_o && wb_ready_i;

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(issue_ok) - CNT_W'(pop);
    occupancy_d   = occupancy_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fflags_acc_d  = fflags_acc_q;
    proto_err_d   = proto_err_q | issue_bad | spurious;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Clear takes effect before the popped flags are merged in.
    if (fflags_clr_i) begin
      fflags_acc_d = '0;
    end
    if (pop) begin
      fflags_acc_d = fflags_acc_d | head[FLAG_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      occupancy_q   <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fflags_acc_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      occupancy_q   <= occupancy_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fflags_acc_q  <= fflags_acc_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Storage is reset so the head output is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {apu_rdata_i, apu_rflags_i};
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_resp_buffer.sv
// Directed self-checking bench for cv32e40p_apu_resp_buffer (DEPTH=4, FLAG_W=5).
module tb_cv32e40p_apu_resp_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue;
  logic        issue_allow;
  logic        apu_rvalid;
  logic [31:0] apu_rdata;
  logic [4:0]  apu_rflags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_rdata;
  logic [4:0]  wb_rflags;
  logic [4:0]  fflags_acc;
  logic        fflags_clr;
  logic [2:0]  outstanding;
  logic        proto_err;

  int checks = 0;
  int fails  = 0;

  cv32e40p_apu_resp_buffer #(.DEPTH(4), .FLAG_W(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .issue_i       (issue),
    .issue_allow_o (issue_allow),
    .apu_rvalid_i  (apu_rvalid),
    .apu_rdata_i   (apu_rdata),
    .apu_rflags_i  (apu_rflags),
    .wb_valid_o    (wb_valid),
    .wb_ready_i    (wb_ready),
    .wb_rdata_o    (wb_rdata),
    .wb_rflags_o   (wb_rflags),
    .fflags_acc_o  (fflags_acc),
    .fflags_clr_i  (fflags_clr),
    .outstanding_o (outstanding),
    .proto_err_o   (proto_err)
  );

  always #5 clk = ~clk;

  // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue      = 1'b0;
    apu_rvalid = 1'b0;
    apu_rdata  = 32'h0;
    apu_rflags = 5'h0;
    wb_ready   = 1'b0;
    fflags_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [31:0] d, input logic [4:0] f);
    apu_rvalid = 1'b1;
    apu_rdata  = d;
    apu_rflags = f;
    step();
    apu_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    checks++; if (issue_allow !== 1'b1) begin fails++; $display("FAIL reset_issue_allow: got %0b want 1", issue_allow); end
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
    checks++; if (wb_rdata !== 32'h0) begin fails++; $display("FAIL reset_wb_rdata: got %h want 0", wb_rdata); end
    checks++; if (wb_rflags !== 5'h0) begin fails++; $display("FAIL reset_wb_rflags: got %b want 0", wb_rflags); end
    checks++; if (fflags_acc !== 5'h0) begin fails++; $display("FAIL reset_fflags_acc: got %b want 0", fflags_acc); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %0b want 0", proto_err); end
    rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_single_op();
    do_reset();
    wb_ready = 1'b1;
    issue = 1'b1;
    step();
    issue = 1'b0;
    checks++; if (outstanding !== 3'd1) begin fails++; $display("FAIL single_outstanding_issue: got %0d want 1", outstanding); end
    step();
    step();
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL single_valid_early: got %0b want 0", wb_valid); end
    push_one(32'h3F80_0000, 5'b00001);
    checks++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", wb_valid); end
    checks++; if (wb_rdata !== 32'h3F80_0000) begin fails++; $display("FAIL single_rdata: got %h want 3f800000", wb_rdata); end
    checks++; if (wb_rflags !== 5'b00001) begin fails++; $display("FAIL single_rflags: got %b want 00001", wb_rflags); end
    $display("txn single pop rdata=%h rflags=%b", wb_rdata, wb_rflags);
    step();
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL single_valid_after: got %0b want 0", wb_valid); end
    checks++; if (fflags_acc !== 5'b00001) begin fails++; $display("FAIL single_fflags: got %b want 00001", fflags_acc); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL single_outstanding_end: got %0d want 0", outstanding); end
    wb_ready = 1'b0;
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (issue_allow !== 1'b1) begin fails++; $display("FAIL credit_allow_%0d: got %0b want 1", i, issue_allow); end
      issue = 1'b1;
      step();
    end
    issue = 1'b0;
    checks++; if (issue_allow !== 1'b0) begin fails++; $display("FAIL credit_allow_full: got %0b want 0", issue_allow); end
    checks++; if (outstanding !== 3'd4) begin fails++; $display("FAIL credit_outstanding_full: got %0d want 4", outstanding); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL credit_no_err_yet: got %0b want 0", proto_err); end
    issue = 1'b1;
    step();
    issue = 1'b0;
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL credit_proto_err: got %0b want 1", proto_err); end
    checks++; if (outstanding !== 3'd4) begin fails++; $display("FAIL credit_outstanding_5th: got %0d want 4", outstanding); end
    for (int i = 0; i < 4; i++) push_one(32'h10 + i, 5'h0);
    checks++; if (issue_allow !== 1'b0) begin fails++; $display("FAIL credit_allow_buffered: got %0b want 0", issue_allow); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    checks++; if (issue_allow !== 1'b1) begin fails++; $display("FAIL credit_allow_after_pop: got %0b want 1", issue_allow); end
    checks++; if (outstanding !== 3'd3) begin fails++; $display("FAIL credit_outstanding_pop: got %0d want 3", outstanding); end
    checks++; if (wb_rdata !== 32'h11) begin fails++; $display("FAIL credit_next_head: got %h want 11", wb_rdata); end
    $display("txn credit limit done outstanding=%0d", outstanding);
  endtask

  task automatic test_backpressure_order();
    logic [31:0] exp [3];
    exp[0] = 32'hA; exp[1] = 32'hB; exp[2] = 32'hC;
    do_reset();
    issue = 1'b1;
    step(); step(); step();
    issue = 1'b0;
    for (int i = 0; i < 3; i++) push_one(exp[i], 5'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (wb_rdata !== 32'hA) begin fails++; $display("FAIL bp_hold_%0d: got %h want a", i, wb_rdata); end
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_valid !== 1'b1 || wb_rdata !== exp[i]) begin fails++; $display("FAIL bp_pop_%0d: got valid=%0b data=%h want valid=1 data=%h", i, wb_valid, wb_rdata, exp[i]); end
      $display("txn bp pop rdata=%h", wb_rdata);
      step();
    end
    wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %0b want 0", wb_valid); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL bp_outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    issue = 1'b1;
    step(); step();
    issue = 1'b0;
    push_one(32'd100, 5'h0);
    checks++; if (outstanding !== 3'd2 || wb_valid !== 1'b1) begin fails++; $display("FAIL sim_setup: got out=%0d valid=%0b want out=2 valid=1", outstanding, wb_valid); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (wb_rdata !== 32'(100 + k)) begin fails++; $display("FAIL sim_head_%0d: got %0d want %0d", k, wb_rdata, 100 + k); end
      issue      = 1'b1;
      apu_rvalid = 1'b1;
      apu_rdata  = 32'(101 + k);
      apu_rflags = 5'h0;
      wb_ready   = 1'b1;
      step();
      checks++; if (outstanding !== 3'd2 || wb_valid !== 1'b1 || proto_err !== 1'b0) begin fails++; $display("FAIL sim_state_%0d: got out=%0d valid=%0b err=%0b want 2 1 0", k, outstanding, wb_valid, proto_err); end
      $display("txn sim op %0d head=%0d", k, wb_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_flags();
    do_reset();
    issue = 1'b1;
    step(); step(); step();
    issue = 1'b0;
    push_one(32'h1, 5'b10000);
    push_one(32'h2, 5'b00100);
    push_one(32'h3, 5'b00001);
    wb_ready = 1'b1;
    step();
    checks++; if (fflags_acc !== 5'b10000) begin fails++; $display("FAIL flags_first: got %b want 10000", fflags_acc); end
    step();
    wb_ready = 1'b0;
    checks++; if (fflags_acc !== 5'b10100) begin fails++; $display("FAIL flags_accum: got %b want 10100", fflags_acc); end
    wb_ready   = 1'b1;
    fflags_clr = 1'b1;
    step();
    wb_ready   = 1'b0;
    checks++; if (fflags_acc !== 5'b00001) begin fails++; $display("FAIL flags_clr_pop: got %b want 00001", fflags_acc); end
    step();
    fflags_clr = 1'b0;
    checks++; if (fflags_acc !== 5'b00000) begin fails++; $display("FAIL flags_clr_only: got %b want 00000", fflags_acc); end
    $display("txn flags done acc=%b", fflags_acc);
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    push_one(32'hDEAD, 5'b11111);
    checks++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL spur_valid: got %0b want 0", wb_valid); end
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL spur_proto_err: got %0b want 1", proto_err); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL spur_outstanding: got %0d want 0", outstanding); end
    issue = 1'b1;
    step(); step(); step();
    issue = 1'b0;
    push_one(32'h55, 5'b00010);
    push_one(32'h66, 5'b00100);
    push_one(32'h77, 5'b01000);
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL spur_err_sticky: got %0b want 1", proto_err); end
    checks++; if (wb_valid !== 1'b1 || wb_rdata !== 32'h55) begin fails++; $display("FAIL spur_buffered: got valid=%0b data=%h want 1 55", wb_valid, wb_rdata); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_rdata !== 32'h0 || wb_rflags !== 5'h0) begin fails++; $display("FAIL async_rst_wb: got valid=%0b data=%h flags=%b want 0 0 0", wb_valid, wb_rdata, wb_rflags); end
    checks++; if (issue_allow !== 1'b1 || outstanding !== 3'd0 || proto_err !== 1'b0 || fflags_acc !== 5'h0) begin fails++; $display("FAIL async_rst_state: got allow=%0b out=%0d err=%0b acc=%b want 1 0 0 0", issue_allow, outstanding, proto_err, fflags_acc); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b0 || outstanding !== 3'd0) begin fails++; $display("FAIL post_rst: got valid=%0b out=%0d want 0 0", wb_valid, outstanding); end
    $display("txn spurious/reset done");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_op();
    test_credit_limit();
    test_backpressure_order();
    test_simultaneous();
    test_flags();
    test_spurious_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cv32e40p_apu_resp_buffer.md
# cv32e40p_apu_resp_buffer

Response-side buffer placed directly downstream of the FPU wrapper's APU response channel. The FPU cannot be back-pressured (its output ready is tied high), so this block captures every result/flag pair into a small FIFO and presents it to core writeback with a valid/ready handshake. It also meters upstream issue with a credit counter so results can never overflow, and keeps a sticky accumulation of FP exception flags for the fflags CSR.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding operations; power of two, ≥2
- FLAG_W, 5, width of APU status flags (fflags: NV DZ OF UF NX)
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- issue_i  in  1  an APU request was accepted this cycle (apu_req && apu_gnt)
- issue_allow_o  out  1  upstream may issue a new APU request
- apu_rvalid_i  in  1  FPU result valid (single-cycle pulse per result)
- apu_rdata_i  in  32  FPU result
- apu_rflags_i  in  FLAG_W  FPU status flags
- wb_valid_o  out  1  head entry available to writeback
- wb_ready_i  in  1  writeback consumes head entry
- wb_rdata_o  out  32  head result
- wb_rflags_o  out  FLAG_W  head flags
- fflags_acc_o  out  FLAG_W  sticky OR of flags of all consumed results
- fflags_clr_i  in  1  clear fflags_acc_o (CSR write)
- outstanding_o  out  $clog2(DEPTH+1)  issued but not yet consumed operations
- proto_err_o  out  1  sticky protocol-violation flag

## Operation
- Registers: outstanding (0..DEPTH), occupancy (0..DEPTH), rd/wr pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), DEPTH×(32+FLAG_W) storage, fflags_acc, proto_err.
- issue_allow_o = (outstanding < DEPTH); combinational from the register only, no path from issue_i.
- Issue counted: issue_i && issue_allow_o → outstanding +1. issue_i while !issue_allow_o → not counted, proto_err set.
- In-flight = outstanding − occupancy. Push: apu_rvalid_i && in-flight > 0 → write {rdata, rflags} at wr_ptr, wr_ptr+1, occupancy +1. apu_rvalid_i with in-flight == 0 → data dropped, proto_err set. Because occupancy < outstanding ≤ DEPTH on every legal push, the FIFO never overflows.
- Pop: wb_valid_o && wb_ready_i → rd_ptr+1, occupancy −1, outstanding −1. wb_ready_i while empty has no effect.
- Simultaneous issue, push, and pop all apply in the same cycle. Net counter change = sum of individual changes. Legality checks use pre-edge register values.
- wb_valid_o = (occupancy != 0). wb_rdata_o and wb_rflags_o show the entry at rd_ptr and hold stable while wb_valid_o && !wb_ready_i.
- Flag accumulation: on pop, fflags_acc |= popped flags. fflags_clr_i clears first, so clear and pop in the same cycle leave fflags_acc = popped flags. Clear with no pop → 0.
- proto_err_o is cleared only by reset.
- No flush input. Reset is the only way to abandon in-flight operations.

## Timing
- Reset values (asynchronous, while rst_ni = 0): issue_allow_o=1, wb_valid_o=0, wb_rdata_o=0, wb_rflags_o=0, fflags_acc_o=0, outstanding_o=0, proto_err_o=0; pointers and counters = 0. Storage is also reset to 0 so wb_rdata_o is defined.
- Latency: apu_rvalid_i sampled at edge N → wb_valid_o high after edge N. No combinational bypass from apu_* to wb_*.
- Throughput: one push and one pop per cycle sustained; a full FIFO with wb_ready_i=1 drains one entry per cycle.
- issue_allow_o rises the cycle after the pop that brings outstanding below DEPTH.
- Reset asserted mid-operation discards all entries and counts immediately. Upstream must also reset the FPU.

## Test plan
- Single op: issue_i pulse, apu_rvalid_i 3 cycles later with rdata=0x3F800000 and flags=5'b00001, wb_ready_i=1 → wb_valid_o for exactly 1 cycle one cycle after rvalid with the same data; fflags_acc_o=5'b00001; outstanding_o returns to 0.
- Credit limit (DEPTH=4): 4 back-to-back issues with wb_ready_i=0 → issue_allow_o=0 after the 4th. A 5th issue_i sets proto_err_o and outstanding_o stays 4. After the 4 results arrive and one pop, issue_allow_o=1 the next cycle.
- Back-pressure and order: push results 0xA,0xB,0xC with wb_ready_i=0 for 5 cycles → wb_rdata_o holds 0xA; release → pops 0xA,0xB,0xC on consecutive cycles.
- Simultaneous events: outstanding=2, occupancy=1, with issue, push, and pop in the same cycle → outstanding=2, occupancy=1, pointers advance correctly across the DEPTH wrap boundary (run ≥10 ops).
- Flags: pop flags 5'b10000 then 5'b00100 → acc=5'b10100. Clear and pop of 5'b00001 in the same cycle → acc=5'b00001.
- Spurious response: apu_rvalid_i with outstanding=0 → nothing pushed, wb_valid_o stays 0, proto_err_o=1 until rst_ni low. Asserting rst_ni with 3 entries buffered clears all outputs to their reset values.
